mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous 2 KiB memory between two requesters: the instruction-fetch port and the LSU data port.
- Decides who owns the memory each cycle, drives the memory control lines, and routes the registered read data back to the requester that asked for it.
- Sits between the PC/fetch logic and LSU on one side and the unified memory macro on the other.
- Lets the core move from a separate instruction array to a shared memory with stall-based sequencing.

Parameters:
- MEM_WORDS, 512, memory depth in 32-bit words (2 KiB).
- ADDR_W, 9, word-address width, equal to log2(MEM_WORDS).
- MAX_LS_STREAK, 4, number of consecutive LSU grants allowed while a fetch is waiting; the next grant is then forced to fetch.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_if_req  in  1  fetch request, held until granted
- i_if_addr  in  32  fetch byte address, word aligned
- o_if_gnt  out  1  fetch accepted this cycle
- o_if_rvld  out  1  fetch response valid
- o_if_rdata  out  32  fetched instruction
- o_if_err  out  1  fetch response error (out of range)
- i_ls_req  in  1  LSU request, held until granted
- i_ls_wren  in  1  1 = store, 0 = load
- i_ls_addr  in  32  LSU byte address
- i_ls_bmask  in  4  byte-lane enables, already shifted to lane
- i_ls_wdata  in  32  store data, already lane aligned
- o_ls_gnt  out  1  LSU request accepted this cycle
- o_ls_rvld  out  1  LSU response valid (load data or store ack)
- o_ls_rdata  out  32  load data, full word
- o_ls_err  out  1  LSU response error (out of range)
- o_mem_cs  out  1  memory chip select
- o_mem_wren  out  1  memory write enable
- o_mem_addr  out  ADDR_W  memory word address
- o_mem_bmask  out  4  memory byte write mask
- o_mem_wdata  out  32  memory write data
- i_mem_rdata  in  32  memory read data, valid one cycle after cs

Behaviour:
- Reset is asynchronous: all outputs go to 0, the streak counter to 0, and the response owner to NONE. A reset mid-transaction drops any pending response; no rvld is issued after reset is released.
- Grant logic is combinational and given to at most one requester per cycle:
  - The LSU has priority when both requests are high.
  - Exception: when streak == MAX_LS_STREAK and i_if_req = 1, fetch wins.
- Streak counter:
  - Increments on an LSU grant while i_if_req = 1, saturating at MAX_LS_STREAK.
  - Clears on any fetch grant, or on any cycle with i_if_req = 0.
- Memory drive on a granted, in-range request, in the same cycle:
  - o_mem_cs = 1.
  - o_mem_addr = addr[ADDR_W+1:2].
  - Loads and fetches: o_mem_wren = 0.
  - Stores: o_mem_wren = 1, o_mem_bmask = i_ls_bmask, o_mem_wdata = i_ls_wdata.
  - All memory outputs are 0 when nothing is granted.
- In range means addr < 4*MEM_WORDS. An out-of-range request is still granted, but o_mem_cs stays 0 and the response carries err = 1 with rdata = 0.
- Response owner register: NONE, IF, IF_ERR, LS_RD, LS_WR, LS_ERR. It is loaded every cycle from the current grant, so it returns to NONE when nothing is granted.
- Responses come exactly 1 cycle after the grant:
  - IF: o_if_rvld = 1, o_if_rdata = i_mem_rdata.
  - LS_RD: o_ls_rvld = 1, o_ls_rdata = i_mem_rdata.
  - LS_WR: o_ls_rvld = 1, o_ls_rdata = 0.
  - *_ERR: rvld = 1, err = 1.
  - rdata and err are 0 whenever the matching rvld = 0.
- Throughput is fully pipelined: a new grant may coincide with the previous response, so back-to-back grants to the same or different requesters are allowed.
- A requester must hold req and all its attributes stable until gnt. Dropping req before gnt is legal and cancels the request with no response.
- Simultaneous requests: the loser sees gnt = 0 and keeps waiting; there is no internal queue.
- Misaligned word addresses (addr[1:0] ≠ 0) are ignored for address formation. Lane correctness is the LSU's job.

Decomposition:
- package_param additions:
  - enum arb_owner_e {NONE, IF, IF_ERR, LS_RD, LS_WR, LS_ERR}.
  - constant MEM_BYTES = 2048.
- One sub-module, mem_arb_prio: grant selection plus streak counter. Inputs are the two requests; outputs are the two grants.
- Memory muxing and the response register stay in the top level.

Test Plan:
- Fetch only: if_req with addr 0x0, 0x4, 0x8 on consecutive cycles → gnt each cycle; if_rvld one cycle later with mem[0], mem[1], mem[2].
- Collision: if_req and ls_req load 0x100 in the same cycle → ls_gnt = 1, if_gnt = 0; next cycle if_gnt = 1 and ls_rvld carries mem[64].
- Starvation: ls_req held for 8 cycles with if_req high → LSU granted 4 times, fetch granted on the 5th cycle, then LSU resumes.
- Store: ls store addr 0x10, bmask 4'b0100, wdata 0x00AB0000 → mem_wren = 1, mem_addr = 4; ls_rvld next cycle with rdata 0; a reload of 0x10 shows byte 2 = 0xAB and other bytes unchanged.
- Out of range: ls load addr 0x800 and if fetch 0x1000 → mem_cs = 0; rvld with err = 1 and rdata 0 one cycle later.
- Reset: assert i_rst_n = 0 in the cycle after a grant → no rvld after release; all outputs 0; streak restarts at 0.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and types for the fetch/LSU memory port arbiter.
// The memory geometry and the LSU streak limit are defined here.
package mem_port_arbiter_pkg;

    localparam int MEM_WORDS     = 512;
    localparam int ADDR_W        = 9;
    localparam int MAX_LS_STREAK = 4;
    localparam int MEM_BYTES     = 2048;
    localparam int STREAK_W      = $clog2(MAX_LS_STREAK + 1);

    typedef enum logic [2:0] {
        OWN_NONE   = 3'd0,
        OWN_IF     = 3'd1,
        OWN_IF_ERR = 3'd2,
        OWN_LS_RD  = 3'd3,
        OWN_LS_WR  = 3'd4,
        OWN_LS_ERR = 3'd5
    } arb_owner_e;

    // A byte address maps onto the macro only below MEM_BYTES.
    function automatic logic addr_in_range(input logic [31:0] addr);
        return addr < 32'(MEM_BYTES);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, LSU and memory-macro signals around the arbiter.
// Handshake: a requester holds req and its attributes until gnt; the one-cycle response arrives as rvld with rdata/err, both zero when rvld is low.
interface mem_port_arbiter_if;

    logic        i_if_req;
    logic [31:0] i_if_addr;
    logic        o_if_gnt;
    logic        o_if_rvld;
    logic [31:0] o_if_rdata;
    logic        o_if_err;

    logic        i_ls_req;
    logic        i_ls_wren;
    logic [31:0] i_ls_addr;
    logic [3:0]  i_ls_bmask;
    logic [31:0] i_ls_wdata;
    logic        o_ls_gnt;
    logic        o_ls_rvld;
    logic [31:0] o_ls_rdata;
    logic        o_ls_err;

    logic                                     o_mem_cs;
    logic                                     o_mem_wren;
    logic [mem_port_arbiter_pkg::ADDR_W-1:0] o_mem_addr;
    logic [3:0]                               o_mem_bmask;
    logic [31:0]                              o_mem_wdata;
    logic [31:0]                              i_mem_rdata;

    modport slave (
        input  i_if_req, i_if_addr,
        output o_if_gnt, o_if_rvld, o_if_rdata, o_if_err,
        input  i_ls_req, i_ls_wren, i_ls_addr, i_ls_bmask, i_ls_wdata,
        output o_ls_gnt, o_ls_rvld, o_ls_rdata, o_ls_err,
        output o_mem_cs, o_mem_wren, o_mem_addr, o_mem_bmask, o_mem_wdata,
        input  i_mem_rdata
    );

    modport master (
        output i_if_req, i_if_addr,
        input  o_if_gnt, o_if_rvld, o_if_rdata, o_if_err,
        output i_ls_req, i_ls_wren, i_ls_addr, i_ls_bmask, i_ls_wdata,
        input  o_ls_gnt, o_ls_rvld, o_ls_rdata, o_ls_err,
        input  o_mem_cs, o_mem_wren, o_mem_addr, o_mem_bmask, o_mem_wdata,
        output i_mem_rdata
    );

endinterface

// File: rtl/mem_port_arbiter_prio.sv
// Grant selection between fetch and LSU with an anti-starvation streak counter.
// LSU wins collisions unless it has already taken MAX_LS_STREAK grants in a row over a waiting fetch.
module mem_arb_prio
    import mem_port_arbiter_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_if_req,
    input  logic                i_ls_req,
    output logic                o_if_gnt,
    output logic                o_ls_gnt,
    output logic [STREAK_W-1:0] o_streak
);

    logic [STREAK_W-1:0] streak_q;
    logic [STREAK_W-1:0] streak_d;
    logic                force_if;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

    // Grants are held low while reset is asserted so no request leaks through.
    always_comb begin
        force_if = i_if_req && (streak_q == STREAK_W'(MAX_LS_STREAK));
        o_ls_gnt = i_rst_n && i_ls_req && !force_if;
        o_if_gnt = i_rst_n && i_if_req && !o_ls_gnt;
        streak_d = streak_q;
        if (!i_if_req || o_if_gnt) begin
            streak_d = '0;
        end else if (o_ls_gnt && (streak_q != STREAK_W'(MAX_LS_STREAK))) begin
            streak_d = streak_q + STREAK_W'(1);
        end
    end

    assign o_streak = streak_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port 2 KiB memory between instruction fetch and the LSU.
// Drives the macro in the grant cycle and steers the next-cycle read data to the owner.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    mem_port_arbiter_if.slave     bus,
    output arb_owner_e            o_dbg_owner,
    output logic [STREAK_W-1:0]   o_dbg_streak
);

    logic              if_gnt;
    logic              ls_gnt;
    logic              if_in;
    logic              ls_in;
    logic              mem_cs;
    logic              mem_wren;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_bmask;
    logic [31:0]       mem_wdata;
    arb_owner_e        owner_q;
    arb_owner_e        owner_d;

    mem_arb_prio u_prio (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_if_req (bus.i_if_req),
        .i_ls_req (bus.i_ls_req),
        .o_if_gnt (if_gnt),
        .o_ls_gnt (ls_gnt),
        .o_streak (o_dbg_streak)
    );

    // Out-of-range requests are granted but never reach the macro.
    always_comb begin
        if_in     = addr_in_range(bus.i_if_addr);
        ls_in     = addr_in_range(bus.i_ls_addr);
        mem_cs    = 1'b0;
        mem_wren  = 1'b0;
        mem_addr  = '0;
        mem_bmask = '0;
        mem_wdata = '0;
        owner_d   = OWN_NONE;
        if (ls_gnt) begin
            if (ls_in) begin
                mem_cs   = 1'b1;
                mem_addr = bus.i_ls_addr[ADDR_W+1:2];
                if (bus.i_ls_wren) begin
                    mem_wren  = 1'b1;
                    mem_bmask = bus.i_ls_bmask;
                    mem_wdata = bus.i_ls_wdata;
                    owner_d   = OWN_LS_WR;
                end else begin
                    owner_d = OWN_LS_RD;
                end
            end else begin
                owner_d = OWN_LS_ERR;
            end
        end else if (if_gnt) begin
            if (if_in) begin
                mem_cs   = 1'b1;
                mem_addr = bus.i_if_addr[ADDR_W+1:2];
                owner_d  = OWN_IF;
            end else begin
                owner_d = OWN_IF_ERR;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            owner_q <= OWN_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    always_comb begin
        bus.o_if_rvld  = (owner_q == OWN_IF) || (owner_q == OWN_IF_ERR);
        bus.o_if_err   = (owner_q == OWN_IF_ERR);
        bus.o_if_rdata = (owner_q == OWN_IF) ? bus.i_mem_rdata : 32'h0;
        bus.o_ls_rvld  = (owner_q == OWN_LS_RD) || (owner_q == OWN_LS_WR) ||
                         (owner_q == OWN_LS_ERR);
        bus.o_ls_err   = (owner_q == OWN_LS_ERR);
        bus.o_ls_rdata = (owner_q == OWN_LS_RD) ? bus.i_mem_rdata : 32'h0;
    end

    assign bus.o_if_gnt    = if_gnt;
    assign bus.o_ls_gnt    = ls_gnt;
    assign bus.o_mem_cs    = mem_cs;
    assign bus.o_mem_wren  = mem_wren;
    assign bus.o_mem_addr  = mem_addr;
    assign bus.o_mem_bmask = mem_bmask;
    assign bus.o_mem_wdata = mem_wdata;
    assign o_dbg_owner     = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural single-port memory.
// Memory word k is preloaded with 32'hC0DE0000 + k.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic                clk;
    logic                rst_n;
    arb_owner_e          dbg_owner;
    logic [STREAK_W-1:0] dbg_streak;
    logic [31:0]         mem [MEM_WORDS];
    int                  n_vec;
    int                  n_err;

    mem_port_arbiter_if bus ();

    mem_port_arbiter dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .bus          (bus.slave),
        .o_dbg_owner  (dbg_owner),
        .o_dbg_streak (dbg_streak)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // memory macro model: write byte lanes, registered read
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < MEM_WORDS; k++) mem[k] <= 32'hC0DE0000 + 32'(k);
            bus.i_mem_rdata <= 32'h0;
        end else if (bus.o_mem_cs) begin
            if (bus.o_mem_wren) begin
                for (int b = 0; b < 4; b++)
                    if (bus.o_mem_bmask[b]) mem[bus.o_mem_addr][b*8 +: 8] <= bus.o_mem_wdata[b*8 +: 8];
            end else begin
                bus.i_mem_rdata <= mem[bus.o_mem_addr];
            end
        end
    end

    // driver tasks
    task automatic drive_idle();
        bus.i_if_req   = 1'b0;
        bus.i_if_addr  = 32'h0;
        bus.i_ls_req   = 1'b0;
        bus.i_ls_wren  = 1'b0;
        bus.i_ls_addr  = 32'h0;
        bus.i_ls_bmask = 4'h0;
        bus.i_ls_wdata = 32'h0;
    endtask

    task automatic drive_fetch(input logic [31:0] addr);
        bus.i_if_req  = 1'b1;
        bus.i_if_addr = addr;
    endtask

    task automatic drive_ls(input logic wren, input logic [31:0] addr,
                            input logic [3:0] bmask, input logic [31:0] wdata);
        bus.i_ls_req   = 1'b1;
        bus.i_ls_wren  = wren;
        bus.i_ls_addr  = addr;
        bus.i_ls_bmask = bmask;
        bus.i_ls_wdata = wdata;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_idle();
        repeat (2) @(negedge clk);
        drive_fetch(32'h0);
        drive_ls(1'b0, 32'h4, 4'h0, 32'h0);
        #1;
        n_vec++;
        if (bus.o_if_gnt !== 1'b0 || bus.o_ls_gnt !== 1'b0) begin
            n_err++; $display("FAIL rst_gnt: got if=%b ls=%b want 0 0", bus.o_if_gnt, bus.o_ls_gnt);
        end
        n_vec++;
        if (bus.o_mem_cs !== 1'b0 || bus.o_mem_wren !== 1'b0 || bus.o_mem_addr !== '0) begin
            n_err++; $display("FAIL rst_mem: got cs=%b wren=%b addr=%h want 0", bus.o_mem_cs, bus.o_mem_wren, bus.o_mem_addr);
        end
        n_vec++;
        if (bus.o_if_rvld !== 1'b0 || bus.o_ls_rvld !== 1'b0 || dbg_owner !== OWN_NONE || dbg_streak !== '0) begin
            n_err++; $display("FAIL rst_state: got ifv=%b lsv=%b owner=%0d streak=%0d want 0", bus.o_if_rvld, bus.o_ls_rvld, dbg_owner, dbg_streak);
        end
        drive_idle();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fetch_only();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k > 0) begin
                n_vec++;
                if (bus.o_if_rvld !== 1'b1 || bus.o_if_rdata !== 32'hC0DE0000 + 32'(k - 1) || bus.o_if_err !== 1'b0) begin
                    n_err++; $display("FAIL fetch_rsp%0d: got v=%b d=%h want 1 %h", k - 1, bus.o_if_rvld, bus.o_if_rdata, 32'hC0DE0000 + 32'(k - 1));
                end
            end
            drive_fetch(32'(4 * k));
            #1;
            n_vec++;
            if (bus.o_if_gnt !== 1'b1 || bus.o_mem_cs !== 1'b1 || bus.o_mem_wren !== 1'b0 || bus.o_mem_addr !== 9'(k)) begin
                n_err++; $display("FAIL fetch_gnt%0d: got gnt=%b cs=%b wren=%b addr=%0d want 1 1 0 %0d", k, bus.o_if_gnt, bus.o_mem_cs, bus.o_mem_wren, bus.o_mem_addr, k);
            end
        end
        @(negedge clk);
        n_vec++;
        if (bus.o_if_rvld !== 1'b1 || bus.o_if_rdata !== 32'hC0DE0002) begin
            n_err++; $display("FAIL fetch_rsp2: got v=%b d=%h want 1 c0de0002", bus.o_if_rvld, bus.o_if_rdata);
        end
        drive_idle();
        #1;
        n_vec++;
        if (bus.o_if_gnt !== 1'b0 || bus.o_mem_cs !== 1'b0) begin
            n_err++; $display("FAIL fetch_idle: got gnt=%b cs=%b want 0 0", bus.o_if_gnt, bus.o_mem_cs);
        end
        @(negedge clk);
        n_vec++;
        if (bus.o_if_rvld !== 1'b0 || bus.o_if_rdata !== 32'h0) begin
            n_err++; $display("FAIL fetch_norsp: got v=%b d=%h want 0 0", bus.o_if_rvld, bus.o_if_rdata);
        end
    endtask

    task automatic test_collision();
        @(negedge clk);
        drive_fetch(32'h20);
        drive_ls(1'b0, 32'h100, 4'h0, 32'h0);
        #1;
        n_vec++;
        if (bus.o_ls_gnt !== 1'b1 || bus.o_if_gnt !== 1'b0 || bus.o_mem_addr !== 9'd64) begin
            n_err++; $display("FAIL coll_gnt: got ls=%b if=%b addr=%0d want 1 0 64", bus.o_ls_gnt, bus.o_if_gnt, bus.o_mem_addr);
        end
        @(negedge clk);
        bus.i_ls_req = 1'b0;
        n_vec++;
        if (bus.o_ls_rvld !== 1'b1 || bus.o_ls_rdata !== 32'hC0DE0040 || bus.o_if_rvld !== 1'b0) begin
            n_err++; $display("FAIL coll_lsrsp: got v=%b d=%h ifv=%b want 1 c0de0040 0", bus.o_ls_rvld, bus.o_ls_rdata, bus.o_if_rvld);
        end
        #1;
        n_vec++;
        if (bus.o_if_gnt !== 1'b1 || bus.o_ls_gnt !== 1'b0 || bus.o_mem_addr !== 9'd8) begin
            n_err++; $display("FAIL coll_ifgnt: got if=%b ls=%b addr=%0d want 1 0 8", bus.o_if_gnt, bus.o_ls_gnt, bus.o_mem_addr);
        end
        @(negedge clk);
        drive_idle();
        n_vec++;
        if (bus.o_if_rvld !== 1'b1 || bus.o_if_rdata !== 32'hC0DE0008 || bus.o_ls_rvld !== 1'b0 || bus.o_ls_rdata !== 32'h0) begin
            n_err++; $display("FAIL coll_ifrsp: got v=%b d=%h lsv=%b lsd=%h want 1 c0de0008 0 0", bus.o_if_rvld, bus.o_if_rdata, bus.o_ls_rvld, bus.o_ls_rdata);
        end
    endtask

    task automatic test_cancel();
        @(negedge clk);
        drive_fetch(32'h30);
        drive_ls(1'b0, 32'h34, 4'h0, 32'h0);
        @(negedge clk);
        drive_idle();
        #1;
        n_vec++;
        if (bus.o_if_gnt !== 1'b0 || bus.o_mem_cs !== 1'b0) begin
            n_err++; $display("FAIL cancel_gnt: got gnt=%b cs=%b want 0 0", bus.o_if_gnt, bus.o_mem_cs);
        end
        @(negedge clk);
        n_vec++;
        if (bus.o_if_rvld !== 1'b0 || bus.o_ls_rvld !== 1'b0) begin
            n_err++; $display("FAIL cancel_rsp: got ifv=%b lsv=%b want 0 0", bus.o_if_rvld, bus.o_ls_rvld);
        end
    endtask

    task automatic test_starvation();
        logic [7:0] exp_ls;
        int         exp_str [8];
        exp_ls  = 8'b1110_1111;
        exp_str = '{0, 1, 2, 3, 4, 0, 1, 2};
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 5) begin
                n_vec++;
                if (bus.o_if_rvld !== 1'b1 || bus.o_if_rdata !== 32'hC0DE0010) begin
                    n_err++; $display("FAIL starve_ifrsp: got v=%b d=%h want 1 c0de0010", bus.o_if_rvld, bus.o_if_rdata);
                end
            end
            drive_fetch(32'h40);
            drive_ls(1'b0, 32'h0, 4'h0, 32'h0);
            #1;
            n_vec++;
            if (bus.o_ls_gnt !== exp_ls[c] || bus.o_if_gnt !== !exp_ls[c] || dbg_streak !== STREAK_W'(exp_str[c])) begin
                n_err++; $display("FAIL starve_c%0d: got ls=%b if=%b streak=%0d want %b %b %0d", c, bus.o_ls_gnt, bus.o_if_gnt, dbg_streak, exp_ls[c], !exp_ls[c], exp_str[c]);
            end
        end
        @(negedge clk);
        drive_idle();
        n_vec++;
        if (bus.o_ls_rvld !== 1'b1 || bus.o_ls_rdata !== 32'hC0DE0000) begin
            n_err++; $display("FAIL starve_lsrsp: got v=%b d=%h want 1 c0de0000", bus.o_ls_rvld, bus.o_ls_rdata);
        end
        @(negedge clk);
        n_vec++;
        if (dbg_streak !== '0) begin
            n_err++; $display("FAIL starve_clear: got streak=%0d want 0", dbg_streak);
        end
    endtask

    task automatic test_store();
        @(negedge clk);
        drive_ls(1'b1, 32'h10, 4'b0100, 32'h00AB0000);
        #1;
        n_vec++;
        if (bus.o_ls_gnt !== 1'b1 || bus.o_mem_cs !== 1'b1 || bus.o_mem_wren !== 1'b1 || bus.o_mem_addr !== 9'd4 ||
            bus.o_mem_bmask !== 4'b0100 || bus.o_mem_wdata !== 32'h00AB0000) begin
            n_err++; $display("FAIL store_mem: got gnt=%b cs=%b wren=%b addr=%0d bm=%b wd=%h want 1 1 1 4 0100 00ab0000",
                              bus.o_ls_gnt, bus.o_mem_cs, bus.o_mem_wren, bus.o_mem_addr, bus.o_mem_bmask, bus.o_mem_wdata);
        end
        @(negedge clk);
        n_vec++;
        if (bus.o_ls_rvld !== 1'b1 || bus.o_ls_rdata !== 32'h0 || bus.o_ls_err !== 1'b0) begin
            n_err++; $display("FAIL store_ack: got v=%b d=%h e=%b want 1 0 0", bus.o_ls_rvld, bus.o_ls_rdata, bus.o_ls_err);
        end
        drive_ls(1'b0, 32'h10, 4'h0, 32'h0);
        #1;
        n_vec++;
        if (bus.o_ls_gnt !== 1'b1 || bus.o_mem_wren !== 1'b0 || bus.o_mem_bmask !== 4'h0 || bus.o_mem_wdata !== 32'h0) begin
            n_err++; $display("FAIL reload_mem: got gnt=%b wren=%b bm=%b wd=%h want 1 0 0 0", bus.o_ls_gnt, bus.o_mem_wren, bus.o_mem_bmask, bus.o_mem_wdata);
        end
        @(negedge clk);
        drive_idle();
        n_vec++;
        if (bus.o_ls_rvld !== 1'b1 || bus.o_ls_rdata !== 32'hC0AB0004) begin
            n_err++; $display("FAIL reload_rsp: got v=%b d=%h want 1 c0ab0004", bus.o_ls_rvld, bus.o_ls_rdata);
        end
    endtask

    task automatic test_out_of_range();
        @(negedge clk);
        drive_fetch(32'h1000);
        drive_ls(1'b0, 32'h800, 4'h0, 32'h0);
        #1;
        n_vec++;
        if (bus.o_ls_gnt !== 1'b1 || bus.o_if_gnt !== 1'b0 || bus.o_mem_cs !== 1'b0) begin
            n_err++; $display("FAIL oor_lsgnt: got ls=%b if=%b cs=%b want 1 0 0", bus.o_ls_gnt, bus.o_if_gnt, bus.o_mem_cs);
        end
        @(negedge clk);
        bus.i_ls_req = 1'b0;
        n_vec++;
        if (bus.o_ls_rvld !== 1'b1 || bus.o_ls_err !== 1'b1 || bus.o_ls_rdata !== 32'h0) begin
            n_err++; $display("FAIL oor_lsrsp: got v=%b e=%b d=%h want 1 1 0", bus.o_ls_rvld, bus.o_ls_err, bus.o_ls_rdata);
        end
        #1;
        n_vec++;
        if (bus.o_if_gnt !== 1'b1 || bus.o_mem_cs !== 1'b0) begin
            n_err++; $display("FAIL oor_ifgnt: got gnt=%b cs=%b want 1 0", bus.o_if_gnt, bus.o_mem_cs);
        end
        @(negedge clk);
        drive_idle();
        n_vec++;
        if (bus.o_if_rvld !== 1'b1 || bus.o_if_err !== 1'b1 || bus.o_if_rdata !== 32'h0 || bus.o_ls_err !== 1'b0) begin
            n_err++; $display("FAIL oor_ifrsp: got v=%b e=%b d=%h lse=%b want 1 1 0 0", bus.o_if_rvld, bus.o_if_err, bus.o_if_rdata, bus.o_ls_err);
        end
        @(negedge clk);
        n_vec++;
        if (bus.o_if_rvld !== 1'b0 || bus.o_if_err !== 1'b0) begin
            n_err++; $display("FAIL oor_after: got v=%b e=%b want 0 0", bus.o_if_rvld, bus.o_if_err);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        drive_fetch(32'h8);
        drive_ls(1'b0, 32'h0, 4'h0, 32'h0);
        repeat (2) @(negedge clk);
        n_vec++;
        if (dbg_streak !== STREAK_W'(2) || bus.o_ls_rvld !== 1'b1) begin
            n_err++; $display("FAIL rmid_pre: got streak=%0d lsv=%b want 2 1", dbg_streak, bus.o_ls_rvld);
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (bus.o_ls_rvld !== 1'b0 || bus.o_ls_rdata !== 32'h0 || bus.o_ls_gnt !== 1'b0 || bus.o_if_gnt !== 1'b0 ||
            bus.o_mem_cs !== 1'b0 || dbg_streak !== '0 || dbg_owner !== OWN_NONE) begin
            n_err++; $display("FAIL rmid_in: got lsv=%b lsd=%h ls=%b if=%b cs=%b streak=%0d owner=%0d want all 0",
                              bus.o_ls_rvld, bus.o_ls_rdata, bus.o_ls_gnt, bus.o_if_gnt, bus.o_mem_cs, dbg_streak, dbg_owner);
        end
        @(negedge clk);
        drive_idle();
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (bus.o_ls_rvld !== 1'b0 || bus.o_if_rvld !== 1'b0) begin
            n_err++; $display("FAIL rmid_norsp: got lsv=%b ifv=%b want 0 0", bus.o_ls_rvld, bus.o_if_rvld);
        end
        drive_fetch(32'h8);
        drive_ls(1'b0, 32'h0, 4'h0, 32'h0);
        #1;
        n_vec++;
        if (dbg_streak !== '0 || bus.o_ls_gnt !== 1'b1) begin
            n_err++; $display("FAIL rmid_restart: got streak=%0d ls=%b want 0 1", dbg_streak, bus.o_ls_gnt);
        end
        @(negedge clk);
        drive_idle();
        n_vec++;
        if (dbg_streak !== STREAK_W'(1)) begin
            n_err++; $display("FAIL rmid_count: got streak=%0d want 1", dbg_streak);
        end
        @(negedge clk);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_fetch_only();
        test_collision();
        test_cancel();
        test_starvation();
        test_store();
        test_out_of_range();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
